acq_ring_writer: RTL and testbench
==================================

Name: acq_ring_writer

Overview:
Capture controller that sits directly upstream of the trigger detector. It writes the ADC sample stream into a circular acquisition RAM. It forwards each sample, tagged with its RAM address, to the trigger detector. It accepts the confirmed trigger address back and stops after a programmed number of post-trigger samples, then publishes the read-out start address to the HPS.

Parameters:
DATA_WIDTH, 16, sample width
ADDR_WIDTH, 12, RAM index width; DEPTH = 2**ADDR_WIDTH
MEMORY_ADDR_LEN, 32, width of the sample address forwarded to the trigger stage

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
arm  in  1  single-cycle pulse; starts a capture (HPS)
force_trig  in  1  single-cycle pulse; software/auto trigger while ARMED
in_valid  in  1  ADC sample strobe
in_data  in  DATA_WIDTH  ADC sample
pretrig_len  in  ADDR_WIDTH  samples required before trigger accepted (HPS reg)
posttrig_len  in  ADDR_WIDTH  samples written after trigger (HPS reg)
trig_valid  in  1  single-cycle pulse; trig_offset holds a confirmed trigger
trig_offset  in  MEMORY_ADDR_LEN  trigger sample address from trigger stage
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_WIDTH  RAM write address
mem_wdata  out  DATA_WIDTH  RAM write data
out_valid  out  1  sample strobe to trigger stage
out_data  out  DATA_WIDTH  sample to trigger stage
out_address  out  MEMORY_ADDR_LEN  zero-extended RAM address of out_data
start_addr  out  ADDR_WIDTH  oldest sample of the finished record (HPS reg)
trig_addr  out  ADDR_WIDTH  captured trigger address (HPS reg)
busy  out  1  high in FILL/ARMED/POST
done  out  1  high in DONE

Behaviour:
- Reset: state IDLE, wr_ptr=0, all counters 0, every output 0.
- States: IDLE, FILL, ARMED, POST, DONE.
- IDLE or DONE + arm -> FILL. Entering FILL clears pre_cnt, post_cnt and done. wr_ptr is NOT reset; the ring continues.
- arm in FILL/ARMED/POST is ignored.
- Write path: in FILL/ARMED/POST, in_valid=1 registers a write with 1-cycle latency.
  - Next cycle: mem_we=1, mem_addr=wr_ptr, mem_wdata=in_data, out_valid=1, out_data=in_data, out_address={0,wr_ptr}.
  - wr_ptr increments and wraps DEPTH-1 -> 0.
  - mem_we and out_valid are always identical.
  - In IDLE/DONE, samples are dropped: mem_we=out_valid=0.
- FILL: pre_cnt counts accepted writes. Leave for ARMED on the cycle pre_cnt reaches eff_pre. eff_pre = min(pretrig_len, DEPTH-1). pretrig_len=0 -> ARMED on the next cycle.
- ARMED:
  - trig_valid -> trig_addr = trig_offset[ADDR_WIDTH-1:0], go to POST.
  - force_trig (trig_valid low) -> trig_addr = address of the last written sample, go to POST.
  - Both asserted: trig_valid wins.
  - trig_valid or force_trig in any other state is ignored.
- POST: post_cnt counts writes; the trigger sample itself is not counted. Go to DONE on the cycle post_cnt reaches eff_post. eff_post = min(posttrig_len, DEPTH-1-eff_pre). A sample write pending on that cycle still completes. eff_post=0 -> DONE on the next cycle.
- DONE: start_addr = (trig_addr - eff_pre) mod DEPTH. It is registered on entry to DONE and held until the next DONE. Also done=1, busy=0.
- Arithmetic: pointer and address math are ADDR_WIDTH-bit modulo. The counters and the eff_post sum use ADDR_WIDTH+1 bits, so there is no overflow.
- pretrig_len and posttrig_len are sampled on arm. Later register writes do not affect the active capture.
- rst mid-capture: immediate return to IDLE; a pending write is discarded.

Test Plan:
- ADDR_WIDTH=4, pretrig_len=4, posttrig_len=5; arm, continuous in_valid with data 0x100+n:
  - ARMED after 4th write.
  - trig_valid with trig_offset=6 -> DONE after 5 more writes.
  - trig_addr=6, start_addr=2, done=1, mem_we=0 afterwards.
- Wrap: wr_ptr starts at 14 (pre-run), pretrig_len=3:
  - mem_addr sequence 14,15,0,1.
  - trig_offset=1 -> start_addr=14.
- Clamp: pretrig_len=12, posttrig_len=10 -> exactly 3 post-trigger writes (eff_post=3).
- trig_valid during FILL ignored; force_trig in ARMED after write to addr 9 -> trig_addr=9.
- Same-cycle trig_valid (offset 5) and force_trig -> trig_addr=5.
- rst during POST -> next cycle state IDLE, busy=0, done=0, mem_we=0; arm still restarts correctly.

Source files
------------

// File: rtl/acq_ring_writer.sv
// rtl/acq_ring_writer.sv - circular acquisition RAM writer with pre/post trigger capture control
module acq_ring_writer #(
    parameter int DATA_WIDTH      = 16,
    parameter int ADDR_WIDTH      = 12,
    parameter int MEMORY_ADDR_LEN = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       arm,
    input  logic                       force_trig,
    input  logic                       in_valid,
    input  logic [DATA_WIDTH-1:0]      in_data,
    input  logic [ADDR_WIDTH-1:0]      pretrig_len,
    input  logic [ADDR_WIDTH-1:0]      posttrig_len,
    input  logic                       trig_valid,
    input  logic [MEMORY_ADDR_LEN-1:0] trig_offset,
    output logic                       mem_we,
    output logic [ADDR_WIDTH-1:0]      mem_addr,
    output logic [DATA_WIDTH-1:0]      mem_wdata,
    output logic                       out_valid,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic [MEMORY_ADDR_LEN-1:0] out_address,
    output logic [ADDR_WIDTH-1:0]      start_addr,
    output logic [ADDR_WIDTH-1:0]      trig_addr,
    output logic                       busy,
    output logic                       done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_ARMED = 3'd2,
        S_POST  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Largest index of the ring, held one bit wider so the clamp arithmetic cannot wrap.
    localparam logic [ADDR_WIDTH:0] MAX_IDX = {1'b0, {ADDR_WIDTH{1'b1}}};

    state_t                state;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH:0]   pre_cnt;
    logic [ADDR_WIDTH:0]   post_cnt;
    logic [ADDR_WIDTH:0]   eff_pre;
    logic [ADDR_WIDTH:0]   eff_post;

    logic                  accept;
    logic [ADDR_WIDTH:0]   pre_req;
    logic [ADDR_WIDTH:0]   pre_clamp;
    logic [ADDR_WIDTH:0]   post_req;
    logic [ADDR_WIDTH:0]   post_room;
    logic [ADDR_WIDTH:0]   post_clamp;
    logic [ADDR_WIDTH:0]   pre_next;
    logic [ADDR_WIDTH:0]   post_next;

    // Sample acceptance and the arm-time clamping of the pre/post lengths so the record fits the ring.
    always_comb begin
        accept     = in_valid && (state == S_FILL || state == S_ARMED || state == S_POST);
        pre_req    = {1'b0, pretrig_len};
        pre_clamp  = (pre_req > MAX_IDX) ? MAX_IDX : pre_req;
        post_req   = {1'b0, posttrig_len};
        post_room  = MAX_IDX - pre_clamp;
        post_clamp = (post_req > post_room) ? post_room : post_req;
        pre_next   = pre_cnt + 1'b1;
        post_next  = post_cnt + 1'b1;
    end

    // Write path: an accepted sample appears on the RAM port and the trigger stream one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_address <= '0;
        end else begin
            mem_we    <= accept;
            out_valid <= accept;
            if (accept) begin
                mem_addr    <= wr_ptr;
                mem_wdata   <= in_data;
                out_data    <= in_data;
                out_address <= MEMORY_ADDR_LEN'(wr_ptr);
                wr_ptr      <= wr_ptr + 1'b1;
            end
        end
    end

    // Capture sequencer: fill pre-trigger history, wait for a trigger, count post-trigger samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            pre_cnt    <= '0;
            post_cnt   <= '0;
            eff_pre    <= '0;
            eff_post   <= '0;
            trig_addr  <= '0;
            start_addr <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (arm) begin
                        state    <= S_FILL;
                        pre_cnt  <= '0;
                        post_cnt <= '0;
                        eff_pre  <= pre_clamp;
                        eff_post <= post_clamp;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                S_FILL: begin
                    if (eff_pre == '0) begin
                        state <= S_ARMED;
                    end else if (accept) begin
                        pre_cnt <= pre_next;
                        if (pre_next == eff_pre) begin
                            state <= S_ARMED;
                        end
                    end
                end
                S_ARMED: begin
                    if (trig_valid) begin
                        trig_addr <= trig_offset[ADDR_WIDTH-1:0];
                        state     <= S_POST;
                    end else if (force_trig) begin
                        // wr_ptr already points past the most recently accepted sample.
                        trig_addr <= wr_ptr - 1'b1;
                        state     <= S_POST;
                    end
                end
                S_POST: begin
                    if (eff_post == '0) begin
                        state      <= S_DONE;
                        start_addr <= trig_addr - eff_pre[ADDR_WIDTH-1:0];
                        busy       <= 1'b0;
                        done       <= 1'b1;
                    end else if (accept) begin
                        post_cnt <= post_next;
                        if (post_next == eff_post) begin
                            state      <= S_DONE;
                            start_addr <= trig_addr - eff_pre[ADDR_WIDTH-1:0];
                            busy       <= 1'b0;
                            done       <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acq_ring_writer.sv
// tb/tb_acq_ring_writer.sv - directed self-checking bench for acq_ring_writer
module tb_acq_ring_writer;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int ML = 32;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FILL  = 3'd1;
    localparam logic [2:0] ST_ARMED = 3'd2;
    localparam logic [2:0] ST_POST  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic          clk = 1'b0;
    logic          rst;
    logic          arm;
    logic          force_trig;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [AW-1:0] pretrig_len;
    logic [AW-1:0] posttrig_len;
    logic          trig_valid;
    logic [ML-1:0] trig_offset;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [ML-1:0] out_address;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] trig_addr;
    logic          busy;
    logic          done;
    logic [2:0]    st;

    int total = 0;
    int bad   = 0;

    acq_ring_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEMORY_ADDR_LEN(ML)) dut (
        .clk(clk), .rst(rst), .arm(arm), .force_trig(force_trig),
        .in_valid(in_valid), .in_data(in_data),
        .pretrig_len(pretrig_len), .posttrig_len(posttrig_len),
        .trig_valid(trig_valid), .trig_offset(trig_offset),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .out_valid(out_valid), .out_data(out_data), .out_address(out_address),
        .start_addr(start_addr), .trig_addr(trig_addr), .busy(busy), .done(done)
    );

    assign st = dut.state;

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One accepted sample; checks the registered RAM write and the forwarded stream beat.
    task automatic wr(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
        chk({tag, "_we"},    32'(mem_we), 32'd1);
        chk({tag, "_addr"},  32'(mem_addr), 32'(a));
        chk({tag, "_wdata"}, 32'(mem_wdata), 32'(d));
        chk({tag, "_ov"},    32'(out_valid), 32'd1);
        chk({tag, "_od"},    32'(out_data), 32'(d));
        chk({tag, "_oaddr"}, out_address, {28'd0, a});
    endtask

    task automatic do_arm(input logic [AW-1:0] pre, input logic [AW-1:0] post);
        pretrig_len  = pre;
        posttrig_len = post;
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; force_trig = 1'b0; in_valid = 1'b0; in_data = '0;
        pretrig_len = '0; posttrig_len = '0; trig_valid = 1'b0; trig_offset = '0;
        step();
        step();
        chk("rst_state", 32'(st), 32'(ST_IDLE));
        chk("rst_we",    32'(mem_we), 32'd0);
        chk("rst_ov",    32'(out_valid), 32'd0);
        chk("rst_addr",  32'(mem_addr), 32'd0);
        chk("rst_oaddr", out_address, 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_start", 32'(start_addr), 32'd0);
        chk("rst_trig",  32'(trig_addr), 32'd0);
        rst = 1'b0;

        // Basic capture: pre=4, post=5, trigger at offset 6.
        do_arm(4'd4, 4'd5);
        chk("t1_fill0", 32'(st), 32'(ST_FILL));
        chk("t1_busy",  32'(busy), 32'd1);
        for (int n = 0; n < 12; n++) begin
            if (n == 6) begin
                trig_valid  = 1'b1;
                trig_offset = 32'd6;
            end
            wr("t1_wr", AW'(n), 16'(16'h100 + n));
            trig_valid = 1'b0;
            if (n == 2)  chk("t1_fill", 32'(st), 32'(ST_FILL));
            if (n == 3)  chk("t1_armed", 32'(st), 32'(ST_ARMED));
            if (n == 6)  chk("t1_post", 32'(st), 32'(ST_POST));
            if (n == 6)  chk("t1_trig", 32'(trig_addr), 32'd6);
            if (n == 10) chk("t1_post_last", 32'(st), 32'(ST_POST));
        end
        chk("t1_done_st", 32'(st), 32'(ST_DONE));
        chk("t1_done",    32'(done), 32'd1);
        chk("t1_nbusy",   32'(busy), 32'd0);
        chk("t1_start",   32'(start_addr), 32'd2);
        in_valid = 1'b1; in_data = 16'h10c;
        step();
        in_valid = 1'b0;
        chk("t1_drop_we", 32'(mem_we), 32'd0);
        chk("t1_drop_ov", 32'(out_valid), 32'd0);

        // Pre-run to move wr_ptr to 14; force trigger with zero post length.
        do_arm(4'd1, 4'd0);
        chk("t2p_done_clr", 32'(done), 32'd0);
        chk("t2p_fill", 32'(st), 32'(ST_FILL));
        wr("t2p_a", 4'd12, 16'h1aa);
        chk("t2p_armed", 32'(st), 32'(ST_ARMED));
        force_trig = 1'b1;
        wr("t2p_b", 4'd13, 16'h1ab);
        force_trig = 1'b0;
        chk("t2p_post", 32'(st), 32'(ST_POST));
        chk("t2p_trig", 32'(trig_addr), 32'd12);
        step();
        chk("t2p_done", 32'(st), 32'(ST_DONE));
        chk("t2p_start", 32'(start_addr), 32'd11);

        // Wrap across the end of the ring.
        do_arm(4'd3, 4'd2);
        wr("t2_w0", 4'd14, 16'h200);
        wr("t2_w1", 4'd15, 16'h201);
        chk("t2_fill", 32'(st), 32'(ST_FILL));
        wr("t2_w2", 4'd0, 16'h202);
        chk("t2_armed", 32'(st), 32'(ST_ARMED));
        trig_valid = 1'b1; trig_offset = 32'd1;
        wr("t2_w3", 4'd1, 16'h203);
        trig_valid = 1'b0;
        chk("t2_post", 32'(st), 32'(ST_POST));
        chk("t2_trig", 32'(trig_addr), 32'd1);
        wr("t2_w4", 4'd2, 16'h204);
        chk("t2_post2", 32'(st), 32'(ST_POST));
        wr("t2_w5", 4'd3, 16'h205);
        chk("t2_done", 32'(st), 32'(ST_DONE));
        chk("t2_start", 32'(start_addr), 32'd14);

        // Clamp: pre=12, post=10 leaves room for only 3 post-trigger writes.
        do_arm(4'd12, 4'd10);
        for (int n = 0; n < 12; n++) begin
            wr("t3_fill_wr", AW'(n + 4), 16'(16'h300 + n));
            if (n == 10) chk("t3_fill", 32'(st), 32'(ST_FILL));
        end
        chk("t3_armed", 32'(st), 32'(ST_ARMED));
        trig_valid = 1'b1; trig_offset = 32'd15;
        step();
        trig_valid = 1'b0;
        chk("t3_post", 32'(st), 32'(ST_POST));
        wr("t3_p0", 4'd0, 16'h3a0);
        wr("t3_p1", 4'd1, 16'h3a1);
        chk("t3_post2", 32'(st), 32'(ST_POST));
        wr("t3_p2", 4'd2, 16'h3a2);
        chk("t3_done", 32'(st), 32'(ST_DONE));
        chk("t3_start", 32'(start_addr), 32'd3);

        // trig_valid in FILL ignored; force_trig after the write to address 9.
        do_arm(4'd7, 4'd0);
        for (int n = 0; n < 7; n++) begin
            if (n == 2) begin
                trig_valid  = 1'b1;
                trig_offset = 32'd2;
            end
            wr("t4_wr", AW'(n + 3), 16'(16'h400 + n));
            trig_valid = 1'b0;
            if (n == 2) chk("t4_fill_ign", 32'(st), 32'(ST_FILL));
            if (n == 2) chk("t4_trig_keep", 32'(trig_addr), 32'd15);
        end
        chk("t4_armed", 32'(st), 32'(ST_ARMED));
        force_trig = 1'b1;
        step();
        force_trig = 1'b0;
        chk("t4_post", 32'(st), 32'(ST_POST));
        chk("t4_trig", 32'(trig_addr), 32'd9);
        step();
        chk("t4_done", 32'(st), 32'(ST_DONE));
        chk("t4_start", 32'(start_addr), 32'd2);

        // pre=0 arms next cycle; simultaneous trig_valid and force_trig.
        do_arm(4'd0, 4'd1);
        chk("t5_fill", 32'(st), 32'(ST_FILL));
        step();
        chk("t5_armed", 32'(st), 32'(ST_ARMED));
        trig_valid = 1'b1; trig_offset = 32'd5; force_trig = 1'b1;
        step();
        trig_valid = 1'b0; force_trig = 1'b0;
        chk("t5_post", 32'(st), 32'(ST_POST));
        chk("t5_trig", 32'(trig_addr), 32'd5);
        wr("t5_p0", 4'd10, 16'h500);
        chk("t5_done", 32'(st), 32'(ST_DONE));
        chk("t5_start", 32'(start_addr), 32'd5);
        trig_valid = 1'b1; trig_offset = 32'd7;
        step();
        trig_valid = 1'b0;
        chk("t5_done_ign", 32'(trig_addr), 32'd5);

        // Reset in POST, then a fresh capture from wr_ptr 0.
        do_arm(4'd1, 4'd4);
        wr("t6_f0", 4'd11, 16'h600);
        chk("t6_armed", 32'(st), 32'(ST_ARMED));
        trig_valid = 1'b1; trig_offset = 32'd11;
        step();
        trig_valid = 1'b0;
        wr("t6_p0", 4'd12, 16'h601);
        chk("t6_post", 32'(st), 32'(ST_POST));
        rst = 1'b1; in_valid = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0;
        chk("t6_rst_st",   32'(st), 32'(ST_IDLE));
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_done", 32'(done), 32'd0);
        chk("t6_rst_we",   32'(mem_we), 32'd0);
        do_arm(4'd2, 4'd1);
        chk("t6_busy", 32'(busy), 32'd1);
        wr("t6_r0", 4'd0, 16'h610);
        wr("t6_r1", 4'd1, 16'h611);
        chk("t6_armed2", 32'(st), 32'(ST_ARMED));
        trig_valid = 1'b1; trig_offset = 32'd1;
        step();
        trig_valid = 1'b0;
        wr("t6_r2", 4'd2, 16'h612);
        chk("t6_done_st", 32'(st), 32'(ST_DONE));
        chk("t6_done", 32'(done), 32'd1);
        chk("t6_start", 32'(start_addr), 32'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
